// File: rtl/mem_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package     : mem_pkg                                                      |
// | Description : Shared widths, depth and the buffered-store entry type used  |
// |               by write_buffer and its storage sub-module wbuf_fifo.        |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package mem_pkg;

  // Address and data width of the processor/memory byte interface.
  localparam int MEM_WIDTH = 8;

  // Number of stores the buffer can hold (power of two, >= 2).
  localparam int MEM_DEPTH = 4;

  // One buffered store: byte address and the byte to be written there.
  typedef struct packed {
    logic [MEM_WIDTH-1:0] adr;
    logic [MEM_WIDTH-1:0] data;
  } entry_t;

endpackage : mem_pkg
`default_nettype wire

// File: rtl/wbuf_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : wbuf_fifo                                                    |
// | Description : Circular store queue for the write buffer. Holds up to DEPTH |
// |               entries, tracked by head/tail pointers and an occupancy     |
// |               count. Push and pop may happen in the same cycle.           |
// | Ports       : clk_i        - clock, rising edge                            |
// |               rst_ni       - asynchronous active-low reset                 |
// |               push_i       - write push_entry_i at tail (caller ensures   |
// |                              the queue is not full)                        |
// |               pop_i        - retire the head entry (caller ensures the    |
// |                              queue is not empty)                           |
// |               push_entry_i - entry to enqueue                              |
// |               entries_o    - raw storage, for forwarding lookups           |
// |               head_o       - index of the oldest entry                     |
// |               count_o      - number of valid entries, 0..DEPTH             |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module wbuf_fifo
  import mem_pkg::*;
#(
  parameter  int DEPTH = MEM_DEPTH,
  localparam int PW    = $clog2(DEPTH),
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          push_i,
  input  logic          pop_i,
  input  entry_t        push_entry_i,
  output entry_t        entries_o [DEPTH],
  output logic [PW-1:0] head_o,
  output logic [CW-1:0] count_o
);

  entry_t        mem_q [DEPTH];
  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;

  // DEPTH is a power of two, so pointer overflow is the modulo-DEPTH wrap.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (push_i) tail_d = tail_q + PW'(1);
    if (pop_i)  head_d = head_q + PW'(1);
    case ({push_i, pop_i})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Payload storage carries no reset; validity comes from count/head alone.
  always_ff @(posedge clk_i) begin
    if (push_i) mem_q[tail_q] <= push_entry_i;
  end

  assign entries_o = mem_q;
  assign head_o    = head_q;
  assign count_o   = count_q;

endmodule : wbuf_fifo
`default_nettype wire

// File: rtl/write_buffer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : write_buffer                                                 |
// | Description : Posted-store buffer between a processor and a byte memory.  |
// |               Stores are queued and drained in order whenever no load is  |
// |               in progress; loads take the memory port and are forwarded   |
// |               from the youngest matching buffered store when one exists.  |
// | Ports       : clk, reset (async, active low)                               |
// |               cpu_memread/cpu_memwrite/cpu_adr/cpu_writedata - CPU request |
// |               cpu_memdata - load data, cpu_stall - store refused (full)    |
// |               mem_memwrite/mem_adr/mem_writedata - memory request          |
// |               mem_memdata - combinational memory read data                 |
// |               empty - no stores pending                                    |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module write_buffer
  import mem_pkg::*;
#(
  parameter int WIDTH = MEM_WIDTH,  // entry_t fields are sized by MEM_WIDTH
  parameter int DEPTH = MEM_DEPTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cpu_memread,
  input  logic             cpu_memwrite,
  input  logic [WIDTH-1:0] cpu_adr,
  input  logic [WIDTH-1:0] cpu_writedata,
  output logic [WIDTH-1:0] cpu_memdata,
  output logic             cpu_stall,
  output logic             mem_memwrite,
  output logic [WIDTH-1:0] mem_adr,
  output logic [WIDTH-1:0] mem_writedata,
  input  logic [WIDTH-1:0] mem_memdata,
  output logic             empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  entry_t        entries [DEPTH];
  entry_t        push_entry;
  logic [PW-1:0] head;
  logic [CW-1:0] count;
  logic          full;
  logic          push;
  logic          pop;
  logic          fwd_hit;
  logic [WIDTH-1:0] fwd_data;
  logic [PW-1:0] idx;

  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);

  // A full buffer refuses the store even if the head drains this same cycle.
  assign cpu_stall = cpu_memwrite && full;
  assign push      = cpu_memwrite && !full;

  // Any asserted cpu_memread holds the memory port, including a read that
  // arrives together with a store (that pair is handled as a store only).
  assign pop          = !empty && !cpu_memread;
  assign mem_memwrite = pop;

  assign push_entry = '{adr: cpu_adr, data: cpu_writedata};

  wbuf_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i        (clk),
    .rst_ni       (reset),
    .push_i       (push),
    .pop_i        (pop),
    .push_entry_i (push_entry),
    .entries_o    (entries),
    .head_o       (head),
    .count_o      (count)
  );

  assign mem_adr       = pop ? entries[head].adr : cpu_adr;
  assign mem_writedata = entries[head].data;

  // Walk valid entries oldest to youngest; later matches overwrite earlier
  // ones so the youngest store to the address wins.
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    idx      = '0;
    for (int k = 0; k < DEPTH; k++) begin
      idx = head + PW'(k);
      if ((CW'(k) < count) && (entries[idx].adr == cpu_adr)) begin
        fwd_hit  = 1'b1;
        fwd_data = entries[idx].data;
      end
    end
  end

  assign cpu_memdata = fwd_hit ? fwd_data : mem_memdata;

endmodule : write_buffer
`default_nettype wire

// File: tb/tb_write_buffer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_write_buffer                                              |
// | Description : Directed bench for write_buffer with a byte-memory model     |
// |               and a log of every memory write.                             |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_write_buffer;

  logic       clk = 1'b0;
  logic       reset;
  logic       cpu_memread, cpu_memwrite;
  logic [7:0] cpu_adr, cpu_writedata, cpu_memdata;
  logic       cpu_stall, mem_memwrite, empty;
  logic [7:0] mem_adr, mem_writedata, mem_memdata;

  always #5 clk = ~clk;

  write_buffer #(.WIDTH(8), .DEPTH(4)) dut (
    .clk           (clk),
    .reset         (reset),
    .cpu_memread   (cpu_memread),
    .cpu_memwrite  (cpu_memwrite),
    .cpu_adr       (cpu_adr),
    .cpu_writedata (cpu_writedata),
    .cpu_memdata   (cpu_memdata),
    .cpu_stall     (cpu_stall),
    .mem_memwrite  (mem_memwrite),
    .mem_adr       (mem_adr),
    .mem_writedata (mem_writedata),
    .mem_memdata   (mem_memdata),
    .empty         (empty)
  );

  // Memory model: unwritten bytes read as the inverted address.
  logic [7:0]   mem [256];
  logic [255:0] written = '0;
  logic [15:0]  wlog [$];

  assign mem_memdata = written[mem_adr] ? mem[mem_adr] : ~mem_adr;

  always @(posedge clk) begin
    if (mem_memwrite) begin
      mem[mem_adr]     <= mem_writedata;
      written[mem_adr] <= 1'b1;
      wlog.push_back({mem_adr, mem_writedata});
    end
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic rd, input logic wr, input logic [7:0] a, input logic [7:0] d);
    @(posedge clk);
    #1;
    cpu_memread   = rd;
    cpu_memwrite  = wr;
    cpu_adr       = a;
    cpu_writedata = d;
  endtask

  typedef struct packed {
    logic       rd;
    logic       wr;
    logic [7:0] adr;
    logic [7:0] wd;
    logic       e_stall;
    logic       e_mw;
    logic [7:0] e_madr;
    logic [7:0] e_mwd;
    logic       chk_wd;
    logic [7:0] e_rd;
    logic       chk_rd;
    logic       e_empty;
  } vec_t;

  vec_t vec [12];

  logic [15:0] refq [$];
  logic [15:0] exp_e;
  int          cnt;
  int          nst;
  int          n0;
  logic        rdv;
  logic        popv;

  initial begin
    //           rd wr adr    wd     stl mw madr   mwd    cw rdata  cr emp
    vec[0]  = '{1'b0,1'b0,8'h10,8'h00, 1'b0,1'b0,8'h10,8'h00,1'b0,8'h00,1'b0,1'b1};
    vec[1]  = '{1'b0,1'b1,8'h10,8'h2A, 1'b0,1'b0,8'h10,8'h00,1'b0,8'h00,1'b0,1'b1};
    vec[2]  = '{1'b0,1'b0,8'h33,8'h00, 1'b0,1'b1,8'h10,8'h2A,1'b1,8'h00,1'b0,1'b0};
    vec[3]  = '{1'b1,1'b0,8'h10,8'h00, 1'b0,1'b0,8'h10,8'h00,1'b0,8'h2A,1'b1,1'b1};
    vec[4]  = '{1'b1,1'b0,8'h44,8'h00, 1'b0,1'b0,8'h44,8'h00,1'b0,8'hBB,1'b1,1'b1};
    vec[5]  = '{1'b1,1'b1,8'h40,8'h55, 1'b0,1'b0,8'h40,8'h00,1'b0,8'h00,1'b0,1'b1};
    vec[6]  = '{1'b1,1'b1,8'h40,8'h66, 1'b0,1'b0,8'h40,8'h00,1'b0,8'h00,1'b0,1'b0};
    vec[7]  = '{1'b1,1'b0,8'h40,8'h00, 1'b0,1'b0,8'h40,8'h00,1'b0,8'h66,1'b1,1'b0};
    vec[8]  = '{1'b1,1'b0,8'h44,8'h00, 1'b0,1'b0,8'h44,8'h00,1'b0,8'hBB,1'b1,1'b0};
    vec[9]  = '{1'b0,1'b0,8'h00,8'h00, 1'b0,1'b1,8'h40,8'h55,1'b1,8'h00,1'b0,1'b0};
    vec[10] = '{1'b0,1'b0,8'h00,8'h00, 1'b0,1'b1,8'h40,8'h66,1'b1,8'h00,1'b0,1'b0};
    vec[11] = '{1'b1,1'b0,8'h40,8'h00, 1'b0,1'b0,8'h40,8'h00,1'b0,8'h66,1'b1,1'b1};

    // Reset state, with a store request present to exercise cpu_stall.
    reset = 1'b0;
    cpu_memread = 1'b0; cpu_memwrite = 1'b1; cpu_adr = 8'h05; cpu_writedata = 8'h00;
    #2;
    chk("rst_empty", empty, 1'b1);
    chk("rst_mw",    mem_memwrite, 1'b0);
    chk("rst_stall", cpu_stall, 1'b0);
    @(posedge clk); #1;
    cpu_memwrite = 1'b0;
    reset = 1'b1;

    // Table: single store/drain, load hit/miss, forwarding, in-order drain.
    for (int i = 0; i < 12; i++) begin
      drive(vec[i].rd, vec[i].wr, vec[i].adr, vec[i].wd);
      @(negedge clk);
      chk($sformatf("v%0d_stall", i), cpu_stall, vec[i].e_stall);
      chk($sformatf("v%0d_mw", i), mem_memwrite, vec[i].e_mw);
      chk($sformatf("v%0d_madr", i), mem_adr, vec[i].e_madr);
      chk($sformatf("v%0d_empty", i), empty, vec[i].e_empty);
      if (vec[i].chk_wd) chk($sformatf("v%0d_mwd", i), mem_writedata, vec[i].e_mwd);
      if (vec[i].chk_rd) chk($sformatf("v%0d_rdata", i), cpu_memdata, vec[i].e_rd);
    end

    // Fill with the read held high: 4 accepted, 5th stalls, then ordered drain.
    wlog.delete();
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 1'b1, 8'h80 + 8'(i), 8'hC0 + 8'(i));
      @(negedge clk);
      chk($sformatf("fill%0d_stall", i), cpu_stall, (i == 4));
      chk($sformatf("fill%0d_mw", i), mem_memwrite, 1'b0);
    end
    for (int c = 0; c < 8; c++) begin
      drive(1'b0, 1'b0, 8'h00, 8'h00);
    end
    @(negedge clk);
    chk("fill_nwrites", 16'(wlog.size()), 16'd4);
    for (int k = 0; k < 4; k++) begin
      exp_e = {8'h80 + 8'(k), 8'hC0 + 8'(k)};
      if (k < wlog.size()) chk($sformatf("fill_wr%0d", k), wlog[k], exp_e);
    end
    chk("fill_empty", empty, 1'b1);

    // Wrap and concurrent push/pop against a reference queue; stalled stores retry.
    wlog.delete();
    refq.delete();
    cnt = 0;
    nst = 0;
    for (int cyc = 0; cyc < 40 && nst < 10; cyc++) begin
      rdv = ((cyc % 3) != 2);
      drive(rdv, 1'b1, 8'hA0 + 8'(nst), 8'h30 + 8'(3 * nst));
      @(negedge clk);
      chk($sformatf("wrap%0d_stall", cyc), cpu_stall, (cnt == 4));
      chk($sformatf("wrap%0d_empty", cyc), empty, (cnt == 0));
      popv = !rdv && (cnt > 0);
      chk($sformatf("wrap%0d_mw", cyc), mem_memwrite, popv);
      if (popv) begin
        chk($sformatf("wrap%0d_madr", cyc), {mem_adr, mem_writedata}, refq[0]);
        void'(refq.pop_front());
      end
      if (cnt < 4) begin
        refq.push_back({8'hA0 + 8'(nst), 8'h30 + 8'(3 * nst)});
        nst++;
      end
      cnt = refq.size();
    end
    chk("wrap_all_accepted", 16'(nst), 16'd10);
    for (int c = 0; c < 8; c++) begin
      drive(1'b0, 1'b0, 8'h00, 8'h00);
    end
    @(negedge clk);
    chk("wrap_nwrites", 16'(wlog.size()), 16'd10);
    for (int k = 0; k < 10; k++) begin
      exp_e = {8'hA0 + 8'(k), 8'h30 + 8'(3 * k)};
      if (k < wlog.size()) chk($sformatf("wrap_wr%0d", k), wlog[k], exp_e);
    end

    // Reset with 3 stores pending: all discarded, next store drains normally.
    drive(1'b1, 1'b1, 8'h90, 8'h01);
    drive(1'b1, 1'b1, 8'h91, 8'h02);
    drive(1'b1, 1'b1, 8'h92, 8'h03);
    @(posedge clk); #1;
    n0 = wlog.size();
    reset = 1'b0;
    cpu_memread = 1'b0; cpu_memwrite = 1'b1; cpu_adr = 8'h93;
    #1;
    chk("mid_rst_empty", empty, 1'b1);
    chk("mid_rst_mw", mem_memwrite, 1'b0);
    chk("mid_rst_stall", cpu_stall, 1'b0);
    @(posedge clk); #1;
    reset = 1'b1;
    cpu_memwrite = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk($sformatf("post_rst%0d_mw", c), mem_memwrite, 1'b0);
      @(posedge clk); #1;
    end
    chk("post_rst_nwrites", 16'(wlog.size()), 16'(n0));
    drive(1'b0, 1'b1, 8'h20, 8'h77);
    @(negedge clk);
    chk("post_rst_st_mw", mem_memwrite, 1'b0);
    drive(1'b0, 1'b0, 8'h00, 8'h00);
    @(negedge clk);
    chk("post_rst_drain_mw", mem_memwrite, 1'b1);
    chk("post_rst_drain", {mem_adr, mem_writedata}, 16'h2077);
    drive(1'b1, 1'b0, 8'h20, 8'h00);
    @(negedge clk);
    chk("post_rst_empty", empty, 1'b1);
    chk("post_rst_rdata", cpu_memdata, 8'h77);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_write_buffer
`default_nettype wire

// File: doc/write_buffer.md
WRITE_BUFFER -- requirements
Module: write_buffer

Interface
REQ-001 SHALL have parameter WIDTH, default 8, meaning address and data width in bits.
REQ-002 SHALL have parameter DEPTH, default 4, meaning number of buffered stores; power of two, at least 2.
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port cpu_memread, input, 1, processor load request.
REQ-006 SHALL have port cpu_memwrite, input, 1, processor store request.
REQ-007 SHALL have port cpu_adr, input, WIDTH, processor byte address.
REQ-008 SHALL have port cpu_writedata, input, WIDTH, processor store data.
REQ-009 SHALL have port cpu_memdata, output, WIDTH, load data returned to the processor.
REQ-010 SHALL have port cpu_stall, output, 1, store not accepted this cycle.
REQ-011 SHALL have port mem_memwrite, output, 1, write strobe to external byte memory.
REQ-012 SHALL have port mem_adr, output, WIDTH, address to external memory.
REQ-013 SHALL have port mem_writedata, output, WIDTH, write data to external memory.
REQ-014 SHALL have port mem_memdata, input, WIDTH, combinational read data from external memory.
REQ-015 SHALL have port empty, output, 1, no stores pending.

Function
REQ-016 SHALL hold up to DEPTH {adr,data} entries in FIFO order, tracked by head/tail pointers and a count of 0..DEPTH.
REQ-017 SHALL push {cpu_adr,cpu_writedata} at the clock edge when cpu_memwrite=1 and count<DEPTH.
REQ-018 SHALL drive cpu_stall=1 combinationally when cpu_memwrite=1 and count==DEPTH; no push then, even if a pop occurs that cycle.
REQ-019 SHALL drain when count>0 and cpu_memread=0: mem_memwrite=1, mem_adr/mem_writedata = head entry; head pops at that edge.
REQ-020 SHALL give loads priority: when cpu_memread=1, mem_memwrite=0 and mem_adr=cpu_adr; the drain waits.
REQ-021 SHALL return, for a load, the data of the youngest buffered entry whose adr equals cpu_adr; otherwise mem_memdata; combinational, zero latency.
REQ-022 SHALL accept a push and a pop in the same cycle, leaving count unchanged and keeping FIFO order.
REQ-023 SHALL enqueue repeated stores to one address separately (no coalescing); memory sees them in program order.
REQ-024 SHALL treat cpu_memread=1 together with cpu_memwrite=1 as a store only; cpu_memdata is then don't-care.
REQ-025 SHALL wrap pointers modulo DEPTH with no lost or duplicated entries.
REQ-026 SHALL drive mem_adr=cpu_adr, mem_memwrite=0 when idle (count==0, no load).
REQ-027 SHALL drive empty=1 exactly when count==0.

Reset
REQ-028 SHALL, on reset low, asynchronously clear count, head and tail, discarding pending stores, including mid-drain.
REQ-029 SHALL hold mem_memwrite=0, cpu_stall=0, empty=1 while reset is low; entry storage need not be cleared.

Structure
REQ-030 SHALL take WIDTH, DEPTH and the entry type {adr,data} from shared package mem_pkg.
REQ-031 SHALL put the storage, pointers and count in one sub-module, wbuf_fifo; the forwarding compare and port muxing stay in write_buffer.

Verification
REQ-032 Single store: store 0x2A to adr 0x10 on idle memory -> mem_memwrite=1, adr 0x10, data 0x2A on the next cycle; empty=1 after.
REQ-033 Fill: 5 back-to-back stores with cpu_memread held at 1 -> 4 accepted, cpu_stall=1 on the 5th; when the read drops, 4 memory writes in order.
REQ-034 Forwarding: store 0x11 then 0x22 to adr 0x40, load 0x40 before they drain -> cpu_memdata=0x22; after the drain, memory word byte 0 of 0x40 is 0x22.
REQ-035 Miss: buffered store to 0x40, load 0x44 holding 0x99 in memory -> cpu_memdata=0x99 and no write during the load.
REQ-036 Wrap and concurrency: 10 stores with push and pop in the same cycle -> memory contents and order match a reference queue; count never exceeds 4.
REQ-037 Reset mid-operation: 3 entries pending, reset low for 1 cycle -> empty=1, no further mem_memwrite, the next store drains normally.
